// File: rtl/spw_tx_arbiter_if.sv
// rtl/spw_tx_arbiter_if.sv - bundle of requester, time-code and uLight TX signals around the arbiter
//
// Purpose: groups every non-clock/reset signal of spw_tx_arbiter.
//   master modport : the arbiter itself (drives TX core, acks, status)
//   slave modport  : the environment (requesters A/B, time-code source, uLight core)
// Signals:
//   fsm_info[5:0]                                   link FSM state from the uLight core
//   req_a_valid/req_a_data[8:0]/req_a_ack           requester A (bit8=1: control, 0x100 EOP, 0x101 EEP)
//   req_b_valid/req_b_data[8:0]/req_b_ack           requester B
//   tc_valid/tc_data[7:0]/tc_ack                    time-code source
//   data_tx_ready/data_en_to_w/data_tx_to_w[8:0]    data path to the core
//   timec_tx_ready/timec_en_to_tx/timec_tx_to_w[7:0] time-code path to the core
//   owner[1:0], pkt_abort, timeout_evt              status
interface spw_tx_arbiter_if;
    logic [5:0] fsm_info;

    logic       req_a_valid;
    logic [8:0] req_a_data;
    logic       req_a_ack;

    logic       req_b_valid;
    logic [8:0] req_b_data;
    logic       req_b_ack;

    logic       tc_valid;
    logic [7:0] tc_data;
    logic       tc_ack;

    logic       data_tx_ready;
    logic       data_en_to_w;
    logic [8:0] data_tx_to_w;

    logic       timec_tx_ready;
    logic       timec_en_to_tx;
    logic [7:0] timec_tx_to_w;

    logic [1:0] owner;
    logic       pkt_abort;
    logic       timeout_evt;

    modport master (
        input  fsm_info,
        input  req_a_valid, req_a_data,
        output req_a_ack,
        input  req_b_valid, req_b_data,
        output req_b_ack,
        input  tc_valid, tc_data,
        output tc_ack,
        input  data_tx_ready,
        output data_en_to_w, data_tx_to_w,
        input  timec_tx_ready,
        output timec_en_to_tx, timec_tx_to_w,
        output owner, pkt_abort, timeout_evt
    );

    modport slave (
        output fsm_info,
        output req_a_valid, req_a_data,
        input  req_a_ack,
        output req_b_valid, req_b_data,
        input  req_b_ack,
        output tc_valid, tc_data,
        input  tc_ack,
        output data_tx_ready,
        input  data_en_to_w, data_tx_to_w,
        output timec_tx_ready,
        input  timec_en_to_tx, timec_tx_to_w,
        input  owner, pkt_abort, timeout_evt
    );
endinterface

// File: rtl/spw_tx_arbiter.sv
// rtl/spw_tx_arbiter.sv - packet-granular round-robin sharer of one SpaceWire uLight TX port
//
// Purpose: two packet requesters (A, B) and one time-code source share the uLight
//   TX interface. A requester keeps the grant until its EOP/EEP has been handed to
//   the core. Nothing is granted while the link is out of Run. A stalled owner gets
//   an EEP inserted after TIMEOUT_CYC empty cycles; link loss cuts the packet.
// Ports:
//   clk_clk     in   system clock, rising edge
//   reset_reset in   asynchronous active-high reset
//   bus         master modport of spw_tx_arbiter_if (all handshakes and status)
// Parameters:
//   TIMEOUT_CYC idle cycles mid-packet before a forced EEP (>= 2)
//   CNT_W       timeout counter width, must hold TIMEOUT_CYC
//   RUN_BIT     fsm_info bit that is 1 while the link is in Run
module spw_tx_arbiter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11,
    parameter int RUN_BIT     = 5
) (
    input logic              clk_clk,
    input logic              reset_reset,
    spw_tx_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_OWN       = 2'd1;
    localparam logic [1:0] S_FORCE_EEP = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam logic [8:0] CHAR_EEP = 9'h101;

    // Counter is compared before incrementing, so the force happens on the
    // TIMEOUT_CYC-th consecutive empty cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic             run;

    logic [1:0]       state;
    logic [1:0]       owner_q;
    logic             last_b;       // 1 when B was the most recently released owner
    logic             data_en_q;
    logic [8:0]       data_q;
    logic             ack_a_q;
    logic             ack_b_q;
    logic [CNT_W-1:0] idle_cnt;
    logic             pkt_started;  // at least one char of the current packet acked
    logic             tevt_q;
    logic             abort_q;

    logic             tc_en_q;
    logic [7:0]       tc_q;
    logic             tc_ack_q;

    logic             owner_valid;
    logic [8:0]       owner_data;

    assign run = bus.fsm_info[RUN_BIT];

    // Only the current owner's request is ever looked at; the other side
    // waits silently until the next arbitration.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = 9'h000;
        if (owner_q == OWN_A) begin
            owner_valid = bus.req_a_valid;
            owner_data  = bus.req_a_data;
        end else if (owner_q == OWN_B) begin
            owner_valid = bus.req_b_valid;
            owner_data  = bus.req_b_data;
        end
    end

    // Data path: arbitration, char slot, timeout and link-loss handling.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= S_IDLE;
            owner_q     <= OWN_NONE;
            last_b      <= 1'b1;
            data_en_q   <= 1'b0;
            data_q      <= 9'h000;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            idle_cnt    <= '0;
            pkt_started <= 1'b0;
            tevt_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            tevt_q  <= 1'b0;
            abort_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Grant cycle sets the owner only; the first char is
                    // loaded on the following edge.
                    if (run && (bus.req_a_valid || bus.req_b_valid)) begin
                        if (bus.req_a_valid && (!bus.req_b_valid || last_b)) begin
                            owner_q <= OWN_A;
                        end else begin
                            owner_q <= OWN_B;
                        end
                        state       <= S_OWN;
                        idle_cnt    <= '0;
                        pkt_started <= 1'b0;
                    end
                end

                S_OWN: begin
                    if (!run) begin
                        // Link loss: the slot content was already acked, so
                        // it is simply dropped.
                        abort_q   <= pkt_started;
                        data_en_q <= 1'b0;
                        data_q    <= 9'h000;
                        last_b    <= (owner_q == OWN_B);
                        owner_q   <= OWN_NONE;
                        state     <= S_IDLE;
                    end else if (data_en_q) begin
                        if (bus.data_tx_ready) begin
                            data_en_q <= 1'b0;
                            if (data_q[8]) begin
                                last_b  <= (owner_q == OWN_B);
                                owner_q <= OWN_NONE;
                                state   <= S_IDLE;
                            end
                        end
                    end else if (owner_valid) begin
                        data_q      <= owner_data;
                        data_en_q   <= 1'b1;
                        ack_a_q     <= (owner_q == OWN_A);
                        ack_b_q     <= (owner_q == OWN_B);
                        idle_cnt    <= '0;
                        pkt_started <= 1'b1;
                    end else if (idle_cnt == CNT_LAST) begin
                        // Owner stalled too long: terminate its packet with EEP.
                        data_q    <= CHAR_EEP;
                        data_en_q <= 1'b1;
                        tevt_q    <= 1'b1;
                        idle_cnt  <= '0;
                        state     <= S_FORCE_EEP;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end

                S_FORCE_EEP: begin
                    // Owner requests are not sampled here; its later chars
                    // go through a fresh arbitration after release.
                    if (!run) begin
                        abort_q   <= 1'b1;
                        data_en_q <= 1'b0;
                        data_q    <= 9'h000;
                        last_b    <= (owner_q == OWN_B);
                        owner_q   <= OWN_NONE;
                        state     <= S_IDLE;
                    end else if (data_en_q && bus.data_tx_ready) begin
                        data_en_q <= 1'b0;
                        last_b    <= (owner_q == OWN_B);
                        owner_q   <= OWN_NONE;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    owner_q   <= OWN_NONE;
                    data_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Time-code path runs independently of the data arbitration.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tc_en_q  <= 1'b0;
            tc_q     <= 8'h00;
            tc_ack_q <= 1'b0;
        end else begin
            tc_ack_q <= 1'b0;
            if (!run) begin
                tc_en_q <= 1'b0;
                tc_q    <= 8'h00;
            end else if (tc_en_q) begin
                if (bus.timec_tx_ready) begin
                    tc_en_q <= 1'b0;
                end
            end else if (bus.tc_valid) begin
                tc_q     <= bus.tc_data;
                tc_en_q  <= 1'b1;
                tc_ack_q <= 1'b1;
            end
        end
    end

    assign bus.req_a_ack      = ack_a_q;
    assign bus.req_b_ack      = ack_b_q;
    assign bus.data_en_to_w   = data_en_q;
    assign bus.data_tx_to_w   = data_q;
    assign bus.owner          = owner_q;
    assign bus.pkt_abort      = abort_q;
    assign bus.timeout_evt    = tevt_q;
    assign bus.tc_ack         = tc_ack_q;
    assign bus.timec_en_to_tx = tc_en_q;
    assign bus.timec_tx_to_w  = tc_q;

endmodule

// File: tb/tb_spw_tx_arbiter.sv
// tb/tb_spw_tx_arbiter.sv - self-checking bench for spw_tx_arbiter against a behavioural model
module tb_spw_tx_arbiter;
    localparam int TO = 1024;

    logic clk_clk = 1'b0;
    logic reset_reset = 1'b1;
    always #5 clk_clk = ~clk_clk;

    spw_tx_arbiter_if bus();

    spw_tx_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(11), .RUN_BIT(5)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Requester / environment state
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    bit         run_k = 1'b1;
    int         rdy_mode = 1;      // 0 never, 1 always, 2 random
    int         tcr_mode = 1;
    int         pva = 100, pvb = 100;
    bit         stall_a = 1'b0, stall_b = 1'b0;
    bit         tc_pend = 1'b0;
    logic [7:0] tc_val = 8'h00;
    bit         random_phase = 1'b0;

    // Behavioural model: owner 0 none / 1 A / 2 B, slot as busy flag + char
    int         m_owner, m_last, m_idle;
    bit         m_busy, m_started, m_eep;
    logic [8:0] m_char;
    bit         m_ack_a, m_ack_b, m_tevt, m_abort;
    bit         m_tc_busy, m_tc_ack;
    logic [7:0] m_tc_char;

    int exp_owner[7] = '{1, 1, 1, 1, 1, 1, 0};
    int exp_en[7]    = '{0, 1, 0, 1, 0, 1, 0};
    int exp_data[7]  = '{0, 'h011, 0, 'h022, 0, 'h100, 0};
    int exp_order[7] = '{1, 1, 1, 2, 2, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = 0; m_last = 2; m_idle = 0;
        m_busy = 0; m_started = 0; m_eep = 0; m_char = 9'h000;
        m_ack_a = 0; m_ack_b = 0; m_tevt = 0; m_abort = 0;
        m_tc_busy = 0; m_tc_ack = 0; m_tc_char = 8'h00;
    endfunction

    function automatic void model_step();
        bit run;
        bit ov;
        run = bus.fsm_info[5];
        m_ack_a = 0; m_ack_b = 0; m_tevt = 0; m_abort = 0; m_tc_ack = 0;

        if (!run) m_tc_busy = 0;
        else if (m_tc_busy) begin
            if (bus.timec_tx_ready) m_tc_busy = 0;
        end else if (bus.tc_valid) begin
            m_tc_busy = 1; m_tc_char = bus.tc_data; m_tc_ack = 1;
        end

        if (m_owner == 0) begin
            if (run && (bus.req_a_valid || bus.req_b_valid)) begin
                if (bus.req_a_valid && bus.req_b_valid) m_owner = 3 - m_last;
                else m_owner = bus.req_a_valid ? 1 : 2;
                m_idle = 0; m_started = 0;
            end
        end else if (!run) begin
            m_abort = m_started || m_eep;
            m_last = m_owner; m_owner = 0; m_busy = 0; m_eep = 0;
        end else if (m_busy) begin
            if (bus.data_tx_ready) begin
                m_busy = 0;
                if (m_char[8]) begin
                    m_last = m_owner; m_owner = 0; m_eep = 0;
                end
            end
        end else begin
            ov = (m_owner == 1) ? bus.req_a_valid : bus.req_b_valid;
            if (ov) begin
                m_char = (m_owner == 1) ? bus.req_a_data : bus.req_b_data;
                m_busy = 1; m_started = 1; m_idle = 0;
                if (m_owner == 1) m_ack_a = 1; else m_ack_b = 1;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_busy = 1; m_char = 9'h101; m_eep = 1; m_tevt = 1; m_idle = 0;
                end
            end
        end
    endfunction

    function automatic void push_pkt(input bit to_b);
        int len;
        len = $urandom_range(4, 1);
        for (int i = 0; i < len; i++) begin
            if (to_b) qb.push_back({1'b0, 8'($urandom)});
            else qa.push_back({1'b0, 8'($urandom)});
        end
        if (to_b) qb.push_back(($urandom_range(9) == 0) ? 9'h101 : 9'h100);
        else qa.push_back(($urandom_range(9) == 0) ? 9'h101 : 9'h100);
    endfunction

    task automatic drive_inputs();
        if (random_phase) begin
            if (qa.size() == 0) push_pkt(1'b0);
            if (qb.size() == 0) push_pkt(1'b1);
            if (run_k) begin
                if ($urandom_range(399) == 0) run_k = 1'b0;
            end else if ($urandom_range(7) == 0) run_k = 1'b1;
            if (!tc_pend && $urandom_range(99) < 5) begin
                tc_pend = 1'b1; tc_val = 8'($urandom);
            end
        end
        bus.fsm_info = {run_k, 5'($urandom)};
        bus.req_a_valid = (qa.size() > 0) && !stall_a && ($urandom_range(99) < pva);
        bus.req_a_data  = (qa.size() > 0) ? qa[0] : 9'($urandom);
        bus.req_b_valid = (qb.size() > 0) && !stall_b && ($urandom_range(99) < pvb);
        bus.req_b_data  = (qb.size() > 0) ? qb[0] : 9'($urandom);
        bus.data_tx_ready  = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(99) < 70);
        bus.timec_tx_ready = (tcr_mode == 1) || (tcr_mode == 2 && $urandom_range(99) < 70);
        bus.tc_valid = tc_pend;
        bus.tc_data  = tc_pend ? tc_val : 8'($urandom);
    endtask

    task automatic compare();
        check("data_en", bus.data_en_to_w, m_busy);
        if (m_busy) check("data_tx", bus.data_tx_to_w, m_char);
        check("req_a_ack", bus.req_a_ack, m_ack_a);
        check("req_b_ack", bus.req_b_ack, m_ack_b);
        check("owner", bus.owner, m_owner);
        check("pkt_abort", bus.pkt_abort, m_abort);
        check("timeout_evt", bus.timeout_evt, m_tevt);
        check("timec_en", bus.timec_en_to_tx, m_tc_busy);
        if (m_tc_busy) check("timec_tx", bus.timec_tx_to_w, m_tc_char);
        check("tc_ack", bus.tc_ack, m_tc_ack);
    endtask

    task automatic tick();
        @(negedge clk_clk);
        compare();
        if (m_ack_a && qa.size() > 0) void'(qa.pop_front());
        if (m_ack_b && qb.size() > 0) void'(qb.pop_front());
        if (m_tc_ack) tc_pend = 1'b0;
        drive_inputs();
        model_step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"},    bus.data_en_to_w, 0);
        check({tag, "_data"},  bus.data_tx_to_w, 0);
        check({tag, "_acka"},  bus.req_a_ack, 0);
        check({tag, "_ackb"},  bus.req_b_ack, 0);
        check({tag, "_owner"}, bus.owner, 0);
        check({tag, "_abort"}, bus.pkt_abort, 0);
        check({tag, "_tevt"},  bus.timeout_evt, 0);
        check({tag, "_tcen"},  bus.timec_en_to_tx, 0);
        check({tag, "_tcd"},   bus.timec_tx_to_w, 0);
        check({tag, "_tcack"}, bus.tc_ack, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset = 1'b1;
        #1;
        check_zero("rst_now");
        @(negedge clk_clk);
        check_zero("rst_hold");
        reset_reset = 1'b0;
        model_reset();
        drive_inputs();
        model_step();
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (qa.size() == 0 && qb.size() == 0 && m_owner == 0 && !m_busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[$];
        int n;
        bit found;
        int tcount;
        logic [8:0] held;

        bus.fsm_info = 6'd0; bus.req_a_valid = 0; bus.req_a_data = 0;
        bus.req_b_valid = 0; bus.req_b_data = 0; bus.tc_valid = 0; bus.tc_data = 0;
        bus.data_tx_ready = 0; bus.timec_tx_ready = 0;
        model_reset();

        // Basic packet from A, ready always high
        qa = '{9'h011, 9'h022, 9'h100};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("basic_owner", bus.owner, exp_owner[i]);
            check("basic_en", bus.data_en_to_w, exp_en[i]);
            check("basic_ack", bus.req_a_ack, exp_en[i]);
            if (exp_en[i] != 0) check("basic_data", bus.data_tx_to_w, exp_data[i]);
        end

        // Tie from reset goes to A, the following tie to B
        qa = '{9'h031, 9'h032, 9'h100, 9'h034, 9'h100};
        qb = '{9'h041, 9'h100};
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.req_a_ack) ord.push_back(1);
            if (bus.req_b_ack) ord.push_back(2);
            if (qa.size() == 0 && qb.size() == 0 && m_owner == 0 && !m_busy) break;
        end
        check("tie_len", ord.size(), 7);
        for (int i = 0; i < 7 && i < ord.size(); i++) check("tie_order", ord[i], exp_order[i]);

        // Owner stall -> forced EEP
        qb = '{9'h055, 9'h066, 9'h100};
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.req_b_ack) begin found = 1'b1; break; end
        end
        check("to_first_ack", found, 1);
        stall_b = 1'b1;
        n = 0; found = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            n++;
            if (bus.timeout_evt) begin found = 1'b1; break; end
        end
        check("to_seen", found, 1);
        check("to_cycles", n, 1025);
        check("to_char", bus.data_tx_to_w, 9'h101);
        check("to_en", bus.data_en_to_w, 1);
        tick();
        check("to_release", bus.owner, 0);
        stall_b = 1'b0;
        drain("to_drain");

        // Core not ready: slot must hold
        qa = '{9'h071, 9'h072, 9'h100};
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.data_en_to_w) break;
        end
        held = bus.data_tx_to_w;
        check("hold_first", held, 9'h071);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_en", bus.data_en_to_w, 1);
            check("hold_data", bus.data_tx_to_w, held);
            check("hold_noack", bus.req_a_ack, 0);
        end
        rdy_mode = 1;
        drain("hold_drain");

        // Link loss while A owns with a full slot
        qa = '{9'h081, 9'h082, 9'h100};
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.data_en_to_w) break;
        end
        run_k = 1'b0;
        tick();
        tick();
        check("loss_en", bus.data_en_to_w, 0);
        check("loss_abort", bus.pkt_abort, 1);
        check("loss_owner", bus.owner, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("loss_nogrant", bus.owner, 0);
            check("loss_pulse", bus.pkt_abort, 0);
        end
        run_k = 1'b1;
        rdy_mode = 1;
        drain("loss_drain");

        // Time-code during an A packet
        qa = '{9'h091, 9'h092, 9'h093, 9'h100};
        tc_pend = 1'b1; tc_val = 8'h3F;
        tcount = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.tc_ack) begin
                tcount++;
                check("tc_value", bus.timec_tx_to_w, 8'h3F);
            end
            if (qa.size() == 0 && m_owner == 0 && !m_busy && !tc_pend) break;
        end
        check("tc_ack_count", tcount, 1);

        // Reset in the middle of a packet
        qa = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h100};
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.req_a_ack) break;
        end
        tick();
        do_reset();

        // Randomized traffic
        random_phase = 1'b1;
        rdy_mode = 2; tcr_mode = 2; pva = 80; pvb = 80;
        for (int i = 0; i < 6000; i++) tick();
        random_phase = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
